// File: rtl/jamma_input_scanner_if.sv
// rtl/jamma_input_scanner_if.sv - JAMMA control bundle between the board harness and the scanner
//
// Purpose: groups the JAMMA bus, coin, DB9 and cleaned-up control signals.
// Modports:
//   master - scanner side: samples jjoy/jcoin/local_joy, drives jselect and the clean vectors
//   slave  - board side: drives jjoy/jcoin/local_joy, observes jselect and the clean vectors
// Signals:
//   jjoy[7:0]      shared JAMMA bus, active-low ([5:0] directions/fire, [7] start)
//   jcoin[1:0]     coin switches, active-low
//   local_joy[5:0] DB9 joystick, active-low
//   jselect        bus mux select, 0 = player 1, 1 = player 2
//   joy1/joy2[7:0] debounced player controls, active-low
//   coin[1:0]      debounced coin switches, active-low
//   scan_done      one-cycle pulse after each complete P1+P2 scan
interface jamma_input_scanner_if;
  logic [7:0] jjoy;
  logic [1:0] jcoin;
  logic [5:0] local_joy;
  logic       jselect;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [1:0] coin;
  logic       scan_done;

  modport master (
    input  jjoy, jcoin, local_joy,
    output jselect, joy1, joy2, coin, scan_done
  );

  modport slave (
    output jjoy, jcoin, local_joy,
    input  jselect, joy1, joy2, coin, scan_done
  );
endinterface

// File: rtl/jamma_input_scanner.sv
// rtl/jamma_input_scanner.sv - settle-timed JAMMA P1/P2 bus scanner with debounce
//
// Purpose: drives jselect, samples the shared JJOY bus once per player after a
// settle interval, debounces each bit over whole scans, and debounces the coin
// switches per clock cycle independently of the scan.
// Ports:
//   pclk  - system clock
//   reset - synchronous, active-high reset
//   bus   - jamma_input_scanner_if.master (jjoy, jcoin, local_joy in;
//           jselect, joy1, joy2, coin, scan_done out)
// Optional feature: define JAMMA_LOCAL_MERGE_EN to AND the synchronised DB9
// joystick into joy1[5:0] without debounce.
module jamma_input_scanner #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DB_SAMPLES     = 4,
  parameter int COIN_DB_CYCLES = 1024
) (
  input  logic                 pclk,
  input  logic                 reset,
  jamma_input_scanner_if.master bus
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0]  DB_TH       = 3'(DB_SAMPLES);
  localparam logic [15:0] COIN_TH     = 16'(COIN_DB_CYCLES);

  typedef enum logic [1:0] {SET1, SAMP1, SET2, SAMP2} state_t;

  state_t      r_state;
  logic [7:0]  r_settle;
  logic        r_jselect;
  logic        r_scan_done;

  logic [7:0]  r_jjoy_m, r_jjoy_s;
  logic [1:0]  r_jcoin_m, r_jcoin_s;
  logic [5:0]  r_local_m, r_local_s;

  // Index 0 = player 1, index 1 = player 2.
  logic [7:0]  r_db [2];
  logic [2:0]  r_db_cnt [2][8];

  logic [1:0]  r_coin;
  logic [15:0] r_coin_cnt [2];

  logic        w_samp;
  logic        w_player;
  logic [7:0]  w_joy1;

  // Two-flop synchronisers; reset to the idle (released) level.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_jjoy_m  <= '1;
      r_jjoy_s  <= '1;
      r_jcoin_m <= '1;
      r_jcoin_s <= '1;
      r_local_m <= '1;
      r_local_s <= '1;
    end else begin
      r_jjoy_m  <= bus.jjoy;
      r_jjoy_s  <= r_jjoy_m;
      r_jcoin_m <= bus.jcoin;
      r_jcoin_s <= r_jcoin_m;
      r_local_m <= bus.local_joy;
      r_local_s <= r_local_m;
    end
  end

  // Scan sequencer. The settle interval covers the external mux delay plus the
  // synchroniser latency before the bus is trusted.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state     <= SET1;
      r_settle    <= '0;
      r_jselect   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= (r_state == SAMP2);
      case (r_state)
        SET1: begin
          if (r_settle == SETTLE_LAST) begin
            r_state  <= SAMP1;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        SAMP1: begin
          r_state   <= SET2;
          r_jselect <= 1'b1;
        end
        SET2: begin
          if (r_settle == SETTLE_LAST) begin
            r_state  <= SAMP2;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        SAMP2: begin
          r_state   <= SET1;
          r_jselect <= 1'b0;
        end
        default: begin
          r_state   <= SET1;
          r_settle  <= '0;
          r_jselect <= 1'b0;
        end
      endcase
    end
  end

  assign w_samp   = (r_state == SAMP1) || (r_state == SAMP2);
  assign w_player = (r_state == SAMP2);

  // Per-bit scan debounce: a bit flips only after DB_SAMPLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        r_db[p] <= 8'hFF;
        for (int i = 0; i < 8; i++) r_db_cnt[p][i] <= '0;
      end
    end else if (w_samp) begin
      for (int i = 0; i < 8; i++) begin
        if (r_jjoy_s[i] == r_db[w_player][i]) begin
          r_db_cnt[w_player][i] <= '0;
        end else if (r_db_cnt[w_player][i] + 3'd1 == DB_TH) begin
          r_db[w_player][i]     <= ~r_db[w_player][i];
          r_db_cnt[w_player][i] <= '0;
        end else if (r_db_cnt[w_player][i] != 3'd7) begin
          r_db_cnt[w_player][i] <= r_db_cnt[w_player][i] + 3'd1;
        end
      end
    end
  end

  // Coin debounce runs every cycle, unrelated to the scan.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_coin <= 2'b11;
      for (int c = 0; c < 2; c++) r_coin_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (r_jcoin_s[c] == r_coin[c]) begin
          r_coin_cnt[c] <= '0;
        end else if (r_coin_cnt[c] + 16'd1 == COIN_TH) begin
          r_coin[c]     <= ~r_coin[c];
          r_coin_cnt[c] <= '0;
        end else if (r_coin_cnt[c] != 16'hFFFF) begin
          r_coin_cnt[c] <= r_coin_cnt[c] + 16'd1;
        end
      end
    end
  end

`ifdef JAMMA_LOCAL_MERGE_EN
  // DB9 presses bypass the debouncer so they appear right after the synchroniser.
  assign w_joy1 = r_db[0] & {2'b11, r_local_s};
`else
  logic w_unused_local;
  assign w_unused_local = ^r_local_s;
  assign w_joy1 = r_db[0];
`endif

  assign bus.jselect   = r_jselect;
  assign bus.joy1      = w_joy1;
  assign bus.joy2      = r_db[1];
  assign bus.coin      = r_coin;
  assign bus.scan_done = r_scan_done;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// tb/tb_jamma_input_scanner.sv - scoreboard bench for jamma_input_scanner
module tb_jamma_input_scanner;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] r_p1 = 8'h00;
  logic [7:0] r_p2 = 8'h00;
  logic [1:0] r_jcoin = 2'b11;
  logic [5:0] r_local = 6'h3F;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  jamma_input_scanner_if bus();

  // Board model: the external mux puts the selected player on the bus.
  assign bus.jjoy      = bus.jselect ? r_p2 : r_p1;
  assign bus.jcoin     = r_jcoin;
  assign bus.local_joy = r_local;

  jamma_input_scanner dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every scan_done pulse with a pending expectation is checked.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge pclk);
      if (!reset && bus.scan_done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan_joy1_joy2", {bus.joy1, bus.joy2}, e);
      end
    end
  end

  task automatic wait_scan();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!bus.scan_done && n < 40);
    check("scan_done_seen", bus.scan_done, 1'b1);
  endtask

  task automatic run_scan(input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] e1, input logic [7:0] e2);
    r_p1 = p1;
    r_p2 = p2;
    exp_q.push_back({e1, e2});
    wait_scan();
  endtask

  // Called on the negedge right after the last reset edge (k = 0).
  task automatic sel_timing(input string tag);
    logic [53:0] a_sel, e_sel, a_done, e_done;
    for (int k = 0; k < 54; k++) begin
      a_sel[k]  = bus.jselect;
      a_done[k] = bus.scan_done;
      e_sel[k]  = ((k % 18) >= 9);
      e_done[k] = (k > 0) && ((k % 18) == 0);
      @(negedge pclk);
    end
    check({tag, "_jselect"}, a_sel, e_sel);
    check({tag, "_scan_done"}, a_done, e_done);
  endtask

  initial begin
    int n;
    logic [7:0] prev;

    // Reset with the bus pulled all-low.
    repeat (3) @(negedge pclk);
    check("rst_joy1", bus.joy1, 8'hFF);
    check("rst_joy2", bus.joy2, 8'hFF);
    check("rst_coin", bus.coin, 2'b11);
    check("rst_jselect", bus.jselect, 1'b0);
    check("rst_scan_done", bus.scan_done, 1'b0);
    r_p1 = 8'hFF;
    r_p2 = 8'hFF;
    reset = 1'b0;
    sel_timing("sel");

    // Player separation.
    wait_scan();
    for (int s = 0; s < 3; s++) run_scan(8'hFE, 8'h7F, 8'hFF, 8'hFF);
    run_scan(8'hFE, 8'h7F, 8'hFE, 8'h7F);
    run_scan(8'hFE, 8'h7F, 8'hFE, 8'h7F);
    for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 8'hFE, 8'h7F);
    run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Glitch rejection on P1 bit 2.
    for (int s = 0; s < 3; s++) run_scan(8'hFB, 8'hFF, 8'hFF, 8'hFF);
    run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int s = 0; s < 3; s++) run_scan(8'hFB, 8'hFF, 8'hFF, 8'hFF);
    r_p1 = 8'hFB;
    exp_q.push_back({8'hFB, 8'hFF});
    prev = bus.joy1;
    n = 0;
    while (!bus.jselect && n < 20) begin
      prev = bus.joy1;
      @(negedge pclk);
      n++;
    end
    check("samp1_pre_joy1", prev, 8'hFF);
    check("samp1_post_joy1", bus.joy1, 8'hFB);
    wait_scan();
    for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 8'hFB, 8'hFF);
    run_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset in the middle of SET2.
    n = 0;
    while (!bus.jselect && n < 20) begin
      @(negedge pclk);
      n++;
    end
    repeat (3) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    check("midrst_jselect", bus.jselect, 1'b0);
    check("midrst_joy1", bus.joy1, 8'hFF);
    reset = 1'b0;
    sel_timing("midrst");

    // Coin: 1023 cycles low is rejected.
    r_jcoin = 2'b10;
    repeat (1023) @(negedge pclk);
    r_jcoin = 2'b11;
    repeat (1030) @(negedge pclk);
    check("coin_1023_rejected", bus.coin, 2'b11);

    // Coin: held low flips exactly at the 1024th synchronised low cycle.
    r_jcoin = 2'b10;
    repeat (1025) @(negedge pclk);
    check("coin_before_thresh", bus.coin, 2'b11);
    @(negedge pclk);
    check("coin_at_thresh", bus.coin, 2'b10);
    r_jcoin = 2'b11;
    repeat (1030) @(negedge pclk);
    check("coin_released", bus.coin, 2'b11);

    // DB9 local joystick.
    r_local = 6'b111110;
    @(negedge pclk);
    check("local_1cyc", bus.joy1, 8'hFF);
    @(negedge pclk);
`ifdef JAMMA_LOCAL_MERGE_EN
    check("local_2cyc", bus.joy1, 8'hFE);
`else
    check("local_2cyc", bus.joy1, 8'hFF);
`endif
    r_local = 6'h3F;
    repeat (3) @(negedge pclk);
    check("local_release", bus.joy1, 8'hFF);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
Name: jamma_input_scanner

Overview:
- Front-end for JAMMA player controls, sitting directly upstream of the arcade core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs.
- Drives the external JSELECT mux line and time-multiplexes the shared 8-bit JJOY bus between player 1 and player 2.
- Synchronises and debounces every input, and produces clean, stable, active-low joystick, start and coin vectors.
- Replaces the free-running per-clock select toggle with settle-timed sampling.

Parameters:
- SETTLE_CYCLES, 8: cycles held after each JSELECT change before sampling; legal range 3..255.
- DB_SAMPLES, 4: consecutive identical samples needed to change a debounced bit; legal range 1..7.
- COIN_DB_CYCLES, 1024: consecutive identical cycles needed to change a debounced coin bit; must fit in 16 bits.

Ports:
- pclk  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high reset
- jjoy  in  8  shared JAMMA bus, active-low, asynchronous; [5:0] directions/fire, [7] start
- jcoin  in  2  coin switches, active-low, asynchronous
- local_joy  in  6  ZX-UNO DB9 joystick, active-low, asynchronous
- jselect  out  1  mux select; 0 = player 1 on the bus, 1 = player 2
- joy1  out  8  debounced player 1 controls, active-low
- joy2  out  8  debounced player 2 controls, active-low
- coin  out  2  debounced coin switches, active-low
- scan_done  out  1  one-cycle pulse after each complete P1+P2 scan

Behaviour:
- Clock and reset: one clock (pclk). Reset is synchronous and active-high.
- Reset values: jselect=0, joy1=8'hFF, joy2=8'hFF, coin=2'b11, scan_done=0.
  - Reset also clears all debounce counters and the settle counter, loads synchroniser flops with 1, and sets FSM=SET1.
  - Reset mid-scan aborts the scan. Partial samples are discarded.
- Synchronisers: jjoy, jcoin and local_joy each pass through 2 flops (jjoy_s, jcoin_s, local_s) before any use.
- FSM states and transitions:
  - SET1: jselect=0. Settle counter counts 0..SETTLE_CYCLES-1, then go to SAMP1.
  - SAMP1: capture jjoy_s into the P1 debouncer (1 cycle), go to SET2.
  - SET2: jselect=1. Count as in SET1, then go to SAMP2.
  - SAMP2: capture jjoy_s into the P2 debouncer (1 cycle), go to SET1. scan_done=1 in the following cycle.
  - Scan period = 2*(SETTLE_CYCLES+1) cycles; with defaults, 18 cycles.
  - jselect is registered and changes on the first cycle of SET1/SET2.
  - The settle counter restarts at 0 on every state entry.
- Per-bit sample debounce (16 bits: P1 and P2):
  - On each sample for that player, if the sample bit equals the output bit, clear its 3-bit counter.
  - Otherwise increment the counter. When the incremented value equals DB_SAMPLES, toggle the output bit and clear the counter.
  - Output updates in the cycle after the qualifying SAMP state.
  - Counters saturate and never wrap.
  - Bits of a player not being sampled hold their value.
- Coin debounce: per bit, a 16-bit cycle counter on jcoin_s, same rule as above but counted every cycle, threshold COIN_DB_CYCLES.
  - Coin is independent of the FSM.
- Boundaries:
  - Bus glitches shorter than DB_SAMPLES scans are rejected.
  - Simultaneous changes on several bits are handled independently per bit.
  - Holding jjoy constant keeps outputs constant indefinitely.

Optional Feature:
- Macro: JAMMA_LOCAL_MERGE_EN.
- Defined: joy1[5:0] = debounced_p1[5:0] & local_s[5:0], so a DB9 press shows up immediately after the synchroniser, with no debounce. joy1[7:6] is the debounced value only.
- Undefined: local_joy is ignored, and joy1 is the pure debounced P1 value.

Test Plan:
- Reset: assert reset for 3 cycles with jjoy=8'h00 -> joy1=joy2=8'hFF, coin=2'b11, jselect=0. Reassert mid-SET2 -> jselect=0 on the next cycle, FSM restarts in SET1.
- Select timing (defaults): jselect=0 for 9 cycles, then 1 for 9 cycles, repeating. scan_done pulses every 18 cycles, one cycle after SAMP2.
- Player separation: bus = 8'hFE while jselect=0 and 8'h7F while jselect=1 -> after 4 scans joy1=8'hFE and joy2=8'h7F, not before the 4th scan.
- Glitch reject: P1 bit2 low for 3 consecutive scans, then high -> joy1 stays 8'hFF throughout. Low for 4 scans -> joy1=8'hFB after SAMP1 of scan 4.
- Coin: jcoin[0] low for 1023 cycles, then high -> coin=2'b11. Held low for 1024+2 cycles -> coin=2'b10.
- JAMMA_LOCAL_MERGE_EN defined: local_joy=6'b111110 with jjoy idle -> joy1=8'hFE two cycles after the input change. Undefined -> joy1 stays 8'hFF.
